victim_write_buffer: RTL

VICTIM_WRITE_BUFFER -- requirements
Module: victim_write_buffer

---
 rtl/victim_write_buffer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/victim_write_buffer.sv
// Victim write buffer: circular FIFO of dirty evicted lines with coalescing,
// youngest-match lookup for miss forwarding, and a one-line-at-a-time drain FSM.
module victim_write_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   evict_write,
    input  logic [ADDR_W-1:0]      evict_addr,
    input  logic [LINE_W-1:0]      evict_wdata,
    output logic                   evict_ready,
    input  logic                   hold,
    input  logic [ADDR_W-1:0]      lookup_addr,
    output logic                   lookup_hit,
    output logic [LINE_W-1:0]      lookup_rdata,
    output logic                   pmem_write,
    output logic [ADDR_W-1:0]      pmem_address,
    output logic [LINE_W-1:0]      pmem_wdata,
    input  logic                   pmem_resp,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [ADDR_W-1:0]  addr_d [DEPTH];
    logic [LINE_W-1:0]  data_q [DEPTH];
    logic [LINE_W-1:0]  data_d [DEPTH];

    logic               coal_match;
    logic [PTR_W-1:0]   coal_idx;
    logic [PTR_W-1:0]   scan_idx;
    logic               push;
    logic               pop;

    // Scan oldest-to-youngest so the last match found is the youngest entry.
    // The head is excluded from coalescing while its write is in flight.
    always_comb begin
        coal_match   = 1'b0;
        coal_idx     = '0;
        lookup_hit   = 1'b0;
        lookup_rdata = '0;
        scan_idx     = head_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (valid_q[scan_idx] && (addr_q[scan_idx] == evict_addr)
                && !((i == 0) && (state_q == DRAIN))) begin
                coal_match = 1'b1;
                coal_idx   = scan_idx;
            end
            if (valid_q[scan_idx] && (addr_q[scan_idx] == lookup_addr)) begin
                lookup_hit   = 1'b1;
                lookup_rdata = data_q[scan_idx];
            end
        end
    end

    assign evict_ready  = (count_q < CNT_W'(DEPTH)) || coal_match;
    assign pmem_write   = (state_q == DRAIN);
    assign pmem_address = addr_q[head_q];
    assign pmem_wdata   = data_q[head_q];
    assign count        = count_q;
    assign empty        = (count_q == '0);

    // Next-state: drain FSM, push/coalesce into storage, pop on write completion.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        push    = evict_write && evict_ready;
        pop     = (state_q == DRAIN) && pmem_resp;

        case (state_q)
            IDLE: begin
                if ((count_q != '0) && !hold) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end

        if (push) begin
            if (coal_match) begin
                data_d[coal_idx] = evict_wdata;
            end else begin
                valid_d[tail_q] = 1'b1;
                addr_d[tail_q]  = evict_addr;
                data_d[tail_q]  = evict_wdata;
                tail_d          = tail_q + PTR_W'(1);
            end
        end

        case ({push && !coal_match, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule
